// File: rtl/index_mask_pkg.sv
// Shared types for the index-to-mask decoder: decode mode and output-side state.
package index_mask_pkg;

  typedef enum logic {MODE_ONEHOT, MODE_THERMO} mask_mode_t;
  typedef enum logic {ST_ACCUM, ST_FULL} state_t;

endpackage

// File: rtl/index_to_mask.sv
// Combinational decode of one bit index into a one-hot bit or a thermometer mask.
module index_to_mask
  import index_mask_pkg::*;
#(
  parameter  int OUTPUT_WIDTH = 8,
  localparam int IDX_W        = $clog2(OUTPUT_WIDTH)
) (
  input  logic [IDX_W-1:0]        index,
  input  mask_mode_t              mode,
  output logic [OUTPUT_WIDTH-1:0] mask,
  output logic                    err
);

  logic [OUTPUT_WIDTH-1:0] raw_mask;

  always_comb begin
    raw_mask = '0;
    for (int i = 0; i < OUTPUT_WIDTH; i++) begin
      if (mode == MODE_ONEHOT) raw_mask[i] = (index == IDX_W'(i));
      else                     raw_mask[i] = (IDX_W'(i) < index);
    end
  end

  // Out-of-range indices would otherwise fill the whole thermometer mask.
  assign err  = ({1'b0, index} >= (IDX_W + 1)'(OUTPUT_WIDTH));
  assign mask = err ? '0 : raw_mask;

endmodule

// File: rtl/index_mask_decoder.sv
// Streaming decoder: ORs decoded index beats into a frame mask and emits it on last.
//
// state    | meaning
// ST_ACCUM | no result held, out_valid = 0
// ST_FULL  | result held on out_*, out_valid = 1
module index_mask_decoder
  import index_mask_pkg::*;
#(
  parameter  int OUTPUT_WIDTH = 8,
  parameter  int CNT_W        = 8,
  localparam int IDX_W        = $clog2(OUTPUT_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IDX_W-1:0]        in_index,
  input  logic                    in_thermo,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] out_mask,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_err
);

  state_t                  state_q, state_d;
  logic [OUTPUT_WIDTH-1:0] acc_mask_q, acc_mask_d;
  logic [CNT_W-1:0]        acc_count_q, acc_count_d;
  logic                    acc_err_q, acc_err_d;
  logic [OUTPUT_WIDTH-1:0] out_mask_q, out_mask_d;
  logic [CNT_W-1:0]        out_count_q, out_count_d;
  logic                    out_err_q, out_err_d;

  logic [OUTPUT_WIDTH-1:0] beat_mask;
  logic                    beat_err;
  logic [CNT_W-1:0]        count_inc;
  logic                    accept;
  logic                    out_hs;

  index_to_mask #(.OUTPUT_WIDTH(OUTPUT_WIDTH)) u_decode (
    .index (in_index),
    .mode  (mask_mode_t'(in_thermo)),
    .mask  (beat_mask),
    .err   (beat_err)
  );

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign count_inc = (acc_count_q == '1) ? acc_count_q : acc_count_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    acc_mask_d  = acc_mask_q;
    acc_count_d = acc_count_q;
    acc_err_d   = acc_err_q;
    out_mask_d  = out_mask_q;
    out_count_d = out_count_q;
    out_err_d   = out_err_q;

    if (accept && in_last) begin
      out_mask_d  = acc_mask_q | beat_mask;
      out_count_d = count_inc;
      out_err_d   = acc_err_q | beat_err;
      acc_mask_d  = '0;
      acc_count_d = '0;
      acc_err_d   = 1'b0;
      state_d     = ST_FULL;
    end else begin
      if (accept) begin
        acc_mask_d  = acc_mask_q | beat_mask;
        acc_count_d = count_inc;
        acc_err_d   = acc_err_q | beat_err;
      end
      if (out_hs) state_d = ST_ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      acc_mask_q  <= '0;
      acc_count_q <= '0;
      acc_err_q   <= 1'b0;
      out_mask_q  <= '0;
      out_count_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_mask_q  <= acc_mask_d;
      acc_count_q <= acc_count_d;
      acc_err_q   <= acc_err_d;
      out_mask_q  <= out_mask_d;
      out_count_q <= out_count_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_mask  = out_mask_q;
  assign out_count = out_count_q;
  assign out_err   = out_err_q;

endmodule
